// File: rtl/spi_sram_bridge_pkg.sv
// Shared definitions for the SPI serial-SRAM bridge: command opcodes and FSM encodings.
package spi_sram_bridge_pkg;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

    typedef enum logic [1:0] {
        BRIDGE_STATE_IDLE  = 2'd0,
        BRIDGE_STATE_SHIFT = 2'd1,
        BRIDGE_STATE_DONE  = 2'd2
    } bridge_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// SCK phase timer: one-cycle tick every CLK_DIV cycles while enabled, held at zero otherwise.
module spi_clk_div #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    logic [7:0] cnt;

    assign tick = en && (cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_sram_bridge.sv
// CPU bus responder that turns each single-byte read/write into one 32-bit mode-0 SPI
// transaction (cmd, addr hi, addr lo, data) on a 23LC512-class serial SRAM.
module spi_sram_bridge
    import spi_sram_bridge_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    input  logic        bus_read,
    input  logic        bus_write,
    output logic [7:0]  bus_data_out,
    output logic        bus_done,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    bridge_state_e state, state_d;
    logic [31:0]   tx, tx_d;
    logic [7:0]    rx, rx_d;
    logic [4:0]    bit_cnt, bit_cnt_d;
    logic          is_rd, is_rd_d;
    logic          cs_n_d, sck_d, mosi_d, done_d;
    logic [7:0]    dout_d;
    logic [7:0]    cmd;
    logic          tick;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .en   (state == BRIDGE_STATE_SHIFT),
        .tick (tick)
    );

    always_comb begin
        state_d   = state;
        tx_d      = tx;
        rx_d      = rx;
        bit_cnt_d = bit_cnt;
        is_rd_d   = is_rd;
        cs_n_d    = spi_cs_n;
        sck_d     = spi_sck;
        mosi_d    = spi_mosi;
        done_d    = 1'b0;
        dout_d    = bus_data_out;
        cmd       = bus_write ? SPI_CMD_WRITE : SPI_CMD_READ;
        case (state)
            BRIDGE_STATE_IDLE: begin
                // Write wins when the CPU raises both strobes.
                if (bus_write || bus_read) begin
                    is_rd_d   = !bus_write;
                    tx_d      = {cmd, bus_address_in, bus_write ? bus_data_in : 8'h00};
                    cs_n_d    = 1'b0;
                    sck_d     = 1'b0;
                    mosi_d    = cmd[7];
                    bit_cnt_d = '0;
                    state_d   = BRIDGE_STATE_SHIFT;
                end
            end
            BRIDGE_STATE_SHIFT: begin
                if (tick) begin
                    sck_d = !spi_sck;
                    if (!spi_sck) begin
                        rx_d = {rx[6:0], spi_miso};
                    end else if (bit_cnt == 5'd31) begin
                        state_d = BRIDGE_STATE_DONE;
                        cs_n_d  = 1'b1;
                        done_d  = 1'b1;
                        mosi_d  = 1'b0;
                        if (is_rd) dout_d = rx;
                    end else begin
                        // MOSI moves only on the falling edge so it is stable at the next rise.
                        tx_d      = {tx[30:0], 1'b0};
                        mosi_d    = tx[30];
                        bit_cnt_d = bit_cnt + 5'd1;
                    end
                end
            end
            BRIDGE_STATE_DONE: state_d = BRIDGE_STATE_IDLE;
            default:           state_d = BRIDGE_STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= BRIDGE_STATE_IDLE;
            spi_cs_n     <= 1'b1;
            spi_sck      <= 1'b0;
            spi_mosi     <= 1'b0;
            bus_done     <= 1'b0;
            bus_data_out <= 8'h00;
        end else begin
            state        <= state_d;
            spi_cs_n     <= cs_n_d;
            spi_sck      <= sck_d;
            spi_mosi     <= mosi_d;
            bus_done     <= done_d;
            bus_data_out <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        tx      <= tx_d;
        rx      <= rx_d;
        bit_cnt <= bit_cnt_d;
        is_rd   <= is_rd_d;
    end

endmodule

// File: tb/tb_spi_sram_bridge.sv
// Bench for spi_sram_bridge: two instances (CLK_DIV 1 and 3) each talking to a behavioural
// serial SRAM that captures the 32-bit frame and serves read data after the address phase.
module tb_spi_sram_bridge;

    logic        clk;
    logic        rst;
    logic        rd   [2];
    logic        wr   [2];
    logic [15:0] addr [2];
    logic [7:0]  wdat [2];
    logic [7:0]  dout [2];
    logic        done [2];
    logic        cs_n [2];
    logic        sck  [2];
    logic        mosi [2];
    logic [7:0]  mem  [0:65535];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : m
        logic [31:0] frame;
        int          rises;
        logic [7:0]  rbyte;
        logic        miso_r;

        spi_sram_bridge #(.CLK_DIV(g == 0 ? 1 : 3)) dut (
            .clk            (clk),
            .rst            (rst),
            .bus_address_in (addr[g]),
            .bus_data_in    (wdat[g]),
            .bus_read       (rd[g]),
            .bus_write      (wr[g]),
            .bus_data_out   (dout[g]),
            .bus_done       (done[g]),
            .spi_cs_n       (cs_n[g]),
            .spi_sck        (sck[g]),
            .spi_mosi       (mosi[g]),
            .spi_miso       (miso_r)
        );

        always @(posedge sck[g] or posedge cs_n[g]) begin
            if (cs_n[g]) begin
                rises <= 0;
            end else begin
                frame <= {frame[30:0], mosi[g]};
                rises <= rises + 1;
            end
        end

        always @(negedge sck[g] or posedge cs_n[g]) begin
            if (cs_n[g]) begin
                miso_r <= 1'b0;
                rbyte  <= 8'h00;
            end else if (rises == 24) begin
                logic [7:0] b;
                b = (frame[23:16] == 8'h03) ? mem[frame[15:0]] : 8'h00;
                miso_r <= b[7];
                rbyte  <= {b[6:0], 1'b0};
            end else if (rises > 24 && rises < 32) begin
                miso_r <= rbyte[7];
                rbyte  <= {rbyte[6:0], 1'b0};
            end
        end
    end

    function automatic logic [31:0] get_frame(input int g);
        return (g == 0) ? m[0].frame : m[1].frame;
    endfunction

    function automatic int get_rises(input int g);
        return (g == 0) ? m[0].rises : m[1].rises;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Issue one CPU request now (just after an edge); the next edge is the accept edge E0.
    task automatic run(input int g, input bit r, input bit w, input logic [15:0] a,
                       input logic [7:0] d, output int lat, output int first_rise,
                       output int hi_cnt);
        rd[g] = r; wr[g] = w; addr[g] = a; wdat[g] = d;
        @(posedge clk); #1;
        lat = -1; first_rise = -1; hi_cnt = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (i == 5) begin
                addr[g] = ~a;
                wdat[g] = ~d;
            end
            if (sck[g] && first_rise < 0) first_rise = i;
            if (sck[g]) hi_cnt++;
            if (done[g]) begin
                lat = i;
                break;
            end
        end
        rd[g] = 1'b0;
        wr[g] = 1'b0;
    endtask

    typedef struct {
        int          g;
        bit          r;
        bit          w;
        logic [15:0] a;
        logic [7:0]  d;
        bit          pre;
        logic [7:0]  mval;
        logic [31:0] frame;
        logic [7:0]  dout;
    } vec_t;

    vec_t v [6];

    initial begin
        int lat, fr, hi, div, gap, pulses;
        bit reached;

        v[0] = '{0, 1'b1, 1'b0, 16'h1234, 8'h00, 1'b1, 8'hA5, 32'h03123400, 8'hA5};
        v[1] = '{0, 1'b0, 1'b1, 16'hBEEF, 8'h5A, 1'b0, 8'h00, 32'h02BEEF5A, 8'hA5};
        v[2] = '{0, 1'b1, 1'b0, 16'hBEEF, 8'h00, 1'b0, 8'h00, 32'h03BEEF00, 8'h5A};
        v[3] = '{1, 1'b1, 1'b0, 16'hFFFF, 8'h00, 1'b1, 8'h3C, 32'h03FFFF00, 8'h3C};
        v[4] = '{0, 1'b1, 1'b1, 16'h00FF, 8'h81, 1'b0, 8'h00, 32'h0200FF81, 8'h5A};
        v[5] = '{1, 1'b0, 1'b1, 16'h8001, 8'hE7, 1'b0, 8'h00, 32'h028001E7, 8'h3C};

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int g = 0; g < 2; g++) begin
            rd[g] = 1'b0; wr[g] = 1'b0; addr[g] = 16'h0000; wdat[g] = 8'h00;
        end

        // Reset with no clock edge yet
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("reset_cs_n", {31'd0, cs_n[0]}, 32'd1);
        chk("reset_sck", {31'd0, sck[0]}, 32'd0);
        chk("reset_mosi", {31'd0, mosi[0]}, 32'd0);
        chk("reset_done", {31'd0, done[0]}, 32'd0);
        chk("reset_dout", {24'd0, dout[0]}, 32'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            div = (v[i].g == 0) ? 1 : 3;
            if (v[i].pre) mem[v[i].a] = v[i].mval;
            run(v[i].g, v[i].r, v[i].w, v[i].a, v[i].d, lat, fr, hi);
            chk($sformatf("v%0d_latency", i), lat, 64 * div);
            chk($sformatf("v%0d_frame", i), get_frame(v[i].g), v[i].frame);
            chk($sformatf("v%0d_dout", i), {24'd0, dout[v[i].g]}, {24'd0, v[i].dout});
            chk($sformatf("v%0d_first_rise", i), fr, div);
            chk($sformatf("v%0d_sck_high_cycles", i), hi, 32 * div);
            chk($sformatf("v%0d_cs_n_at_done", i), {31'd0, cs_n[v[i].g]}, 32'd1);
            chk($sformatf("v%0d_mosi_at_done", i), {31'd0, mosi[v[i].g]}, 32'd0);
            if (v[i].w) mem[v[i].a] = v[i].d;
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_one_cycle", i), {31'd0, done[v[i].g]}, 32'd0);
            @(posedge clk); #1;
        end

        // Back-to-back: write then read re-raised the cycle after bus_done drops
        run(0, 1'b0, 1'b1, 16'h0010, 8'h77, lat, fr, hi);
        chk("b2b_write_latency", lat, 64);
        chk("b2b_write_frame", get_frame(0), 32'h02001077);
        mem[16'h0010] = 8'h77;
        gap = cs_n[0] ? 1 : 0;
        @(posedge clk); #1;
        if (cs_n[0]) gap++;
        chk("b2b_done_dropped", {31'd0, done[0]}, 32'd0);
        run(0, 1'b1, 1'b0, 16'h0010, 8'h00, lat, fr, hi);
        chk("b2b_read_latency", lat, 64);
        chk("b2b_read_frame", get_frame(0), 32'h03001000);
        chk("b2b_read_dout", {24'd0, dout[0]}, 32'h77);
        chk("b2b_cs_gap", gap, 2);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Asynchronous reset mid-cycle clears held read data on both instances
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("areset_dout0", {24'd0, dout[0]}, 32'h00);
        chk("areset_dout1", {24'd0, dout[1]}, 32'h00);
        chk("areset_cs_n1", {31'd0, cs_n[1]}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset after the 10th SCK rise of a read aborts it
        mem[16'h0002] = 8'hAA;
        rd[0] = 1'b1; addr[0] = 16'h0002; wdat[0] = 8'h00;
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (get_rises(0) == 10) begin
                reached = 1'b1;
                break;
            end
        end
        chk("midop_reached_rise10", {31'd0, reached}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midop_cs_n", {31'd0, cs_n[0]}, 32'd1);
        chk("midop_sck", {31'd0, sck[0]}, 32'd0);
        chk("midop_done", {31'd0, done[0]}, 32'd0);
        rd[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done[0]) pulses++;
        end
        chk("midop_no_done", pulses, 0);
        mem[16'h0001] = 8'hC3;
        run(0, 1'b1, 1'b0, 16'h0001, 8'h00, lat, fr, hi);
        chk("post_reset_latency", lat, 64);
        chk("post_reset_frame", get_frame(0), 32'h03000100);
        chk("post_reset_dout", {24'd0, dout[0]}, 32'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
